// File: rtl/char_arbiter.sv
// Round-robin arbiter sharing one byte-strobe channel among N character sources.
// Optional packet lock (hold the channel until i_last) is built when CHAR_ARB_LOCK_EN is defined.
module char_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int GAP = 1
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic [N-1:0]   i_req,
    input  logic [N*W-1:0] i_data,
    input  logic [N-1:0]   i_last,
    input  logic           i_busy,
    output logic [W-1:0]   o_data,
    output logic           o_act,
    output logic [$clog2(N)-1:0] o_src,
    output logic [N-1:0]   o_ack
);

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(GAP + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [SW-1:0]  last_q;
    logic [W-1:0]   data_q;
    logic           act_q;
    logic [SW-1:0]  src_q;
    logic [N-1:0]   ack_q;

    logic [N-1:0]   elig_s;
    logic           found_s;
    logic [SW-1:0]  win_s;
    logic [SW-1:0]  cand_s;
    logic [W-1:0]   win_data_s;

`ifdef CHAR_ARB_LOCK_EN
    logic           lock_vld_q;
    logic [SW-1:0]  lock_idx_q;

    // Restrict eligibility to the locked source while a packet is in flight.
    always_comb begin
        elig_s = i_req & (lock_vld_q ? (N'(1) << lock_idx_q) : {N{1'b1}});
    end
`else
    logic           unused_last_s;
    assign unused_last_s = ^i_last;

    // Every requesting source is eligible in per-byte mode.
    always_comb begin
        elig_s = i_req;
    end
`endif

    // Search downward in offset so the nearest eligible source after last_q wins.
    always_comb begin
        found_s = |elig_s;
        win_s   = '0;
        cand_s  = '0;
        for (int i = N; i >= 1; i--) begin
            cand_s = SW'((int'(last_q) + i) % N);
            if (elig_s[cand_s]) begin
                win_s = cand_s;
            end else begin
                win_s = win_s;
            end
        end
    end

    // Select the winning source's byte.
    always_comb begin
        win_data_s = '0;
        for (int k = 0; k < N; k++) begin
            if (SW'(k) == win_s) begin
                win_data_s = i_data[k*W +: W];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Arbitration FSM with registered strobe outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= SW'(N - 1);
            data_q  <= '0;
            act_q   <= 1'b0;
            src_q   <= '0;
            ack_q   <= '0;
`ifdef CHAR_ARB_LOCK_EN
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_busy && found_s) begin
                        data_q  <= win_data_s;
                        act_q   <= 1'b1;
                        src_q   <= win_s;
                        ack_q   <= N'(1) << win_s;
                        last_q  <= win_s;
                        cnt_q   <= CW'(GAP);
                        state_q <= ST_GAP;
`ifdef CHAR_ARB_LOCK_EN
                        lock_vld_q <= ~i_last[win_s];
                        lock_idx_q <= win_s;
`endif
                    end else begin
                        data_q <= '0;
                        act_q  <= 1'b0;
                        src_q  <= '0;
                        ack_q  <= '0;
                    end
                end
                ST_GAP: begin
                    data_q <= '0;
                    act_q  <= 1'b0;
                    src_q  <= '0;
                    ack_q  <= '0;
                    if (cnt_q <= CW'(1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    data_q  <= '0;
                    act_q   <= 1'b0;
                    src_q   <= '0;
                    ack_q   <= '0;
                end
            endcase
        end
    end

    assign o_data = data_q;
    assign o_act  = act_q;
    assign o_src  = src_q;
    assign o_ack  = ack_q;

endmodule

// File: tb/tb_char_arbiter.sv
// Self-checking bench for char_arbiter: GAP=1 and GAP=3 instances share stimulus and are
// compared each cycle against a timeline model (next-allowed-grant edge, last pointer, lock).
module tb_char_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int PW = W + 1 + 2 + N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           i_reset;
    logic           i_busy;
    logic [N-1:0]   i_req;
    logic [N-1:0]   i_last;
    logic [N*W-1:0] i_data;

    logic [W-1:0] d0, d1;
    logic         a0, a1;
    logic [1:0]   s0, s1;
    logic [N-1:0] k0, k1;

    char_arbiter #(.N(N), .W(W), .GAP(1)) dut_g1 (
        .i_clock(clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
        .i_last(i_last), .i_busy(i_busy),
        .o_data(d0), .o_act(a0), .o_src(s0), .o_ack(k0));

    char_arbiter #(.N(N), .W(W), .GAP(3)) dut_g3 (
        .i_clock(clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
        .i_last(i_last), .i_busy(i_busy),
        .o_data(d1), .o_act(a1), .o_src(s1), .o_ack(k1));

    logic [PW-1:0] got [2];
    assign got[0] = {d0, a0, s0, k0};
    assign got[1] = {d1, a1, s1, k1};

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state, one slot per instance.
    int            gapv   [2] = '{1, 3};
    int            m_last [2];
    longint        m_next [2];
    logic          m_lockv[2];
    int            m_locki[2];
    logic [PW-1:0] exp_v  [2];
    longint        edge_n = 0;

    task automatic tick();
        logic [N-1:0]   req, lst, elig;
        logic [N*W-1:0] dat;
        logic           bsy, rst, granted;
        int             k;
        req = i_req; lst = i_last; dat = i_data; bsy = i_busy; rst = i_reset;
        @(posedge clk);
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            exp_v[d] = '0;
            if (rst) begin
                m_last[d]  = N - 1;
                m_next[d]  = edge_n + 1;
                m_lockv[d] = 1'b0;
            end else if (edge_n >= m_next[d] && !bsy) begin
                elig = req;
`ifdef CHAR_ARB_LOCK_EN
                if (m_lockv[d]) elig = req & (4'b0001 << m_locki[d]);
`endif
                granted = 1'b0;
                for (int s = 1; s <= N; s++) begin
                    k = (m_last[d] + s) % N;
                    if (!granted && elig[k]) begin
                        granted  = 1'b1;
                        exp_v[d] = {dat[k*W +: W], 1'b1, 2'(k), 4'(4'b0001 << k)};
                        m_last[d] = k;
                        m_next[d] = edge_n + gapv[d] + 1;
`ifdef CHAR_ARB_LOCK_EN
                        m_lockv[d] = ~lst[k];
                        m_locki[d] = k;
`endif
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_busy = 1'b0; i_req = '0; i_last = '0; i_data = '0;
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d] !== {PW{1'b0}}) begin
                miscompares++;
                $display("FAIL reset dut%0d: got %h expected %h", d, got[d], {PW{1'b0}});
            end
        end
    endtask

    task automatic test_single();
        i_reset = 1'b0; i_req = 4'b0100; i_data[2*W +: W] = 8'h41;
        tick();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d] !== {8'h41, 1'b1, 2'd2, 4'b0100} || got[d] !== exp_v[d]) begin
                miscompares++;
                $display("FAIL single dut%0d: got %h expected %h", d, got[d], {8'h41, 1'b1, 2'd2, 4'b0100});
            end
        end
        i_req = '0;
        tick();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d] !== {PW{1'b0}}) begin
                miscompares++;
                $display("FAIL single_clear dut%0d: got %h expected 0", d, got[d]);
            end
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        longint prev = 0;
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        i_req = 4'b1111;
        for (int k = 0; k < N; k++) i_data[k*W +: W] = 8'h30 + 8'(k);
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (got[d] !== exp_v[d]) begin
                    miscompares++;
                    $display("FAIL rr dut%0d: got %h expected %h", d, got[d], exp_v[d]);
                end
            end
            if (a0) begin
                vectors++;
                if (s0 !== 2'(n % N) || d0 !== 8'h30 + 8'(n % N) || (n > 0 && edge_n - prev != 2)) begin
                    miscompares++;
                    $display("FAIL rr_seq: got src %0d data %h spacing %0d expected src %0d data %h spacing 2",
                             s0, d0, edge_n - prev, n % N, 8'h30 + 8'(n % N));
                end
                prev = edge_n; n++;
            end
        end
        vectors++;
        if (n != 10) begin
            miscompares++;
            $display("FAIL rr_count: got %0d expected 10", n);
        end
        i_req = '0;
    endtask

    task automatic test_busy();
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        i_busy = 1'b1; i_req = 4'b0010; i_data[1*W +: W] = 8'h5A;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (a0 !== 1'b0 || a1 !== 1'b0 || got[0] !== exp_v[0]) begin
                miscompares++;
                $display("FAIL busy_hold: got act %b/%b expected 0/0", a0, a1);
            end
        end
        i_busy = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d] !== {8'h5A, 1'b1, 2'd1, 4'b0010} || got[d] !== exp_v[d]) begin
                miscompares++;
                $display("FAIL busy_release dut%0d: got %h expected %h", d, got[d], {8'h5A, 1'b1, 2'd1, 4'b0010});
            end
        end
        i_req = '0;
    endtask

    task automatic test_reset_mid();
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        i_req = 4'b1010; i_data[1*W +: W] = 8'h11; i_data[3*W +: W] = 8'h33;
        tick();
        vectors++;
        if (a0 !== 1'b1 || s0 !== 2'd1) begin
            miscompares++;
            $display("FAIL rstmid_first: got act %b src %0d expected act 1 src 1", a0, s0);
        end
        i_reset = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d] !== {PW{1'b0}}) begin
                miscompares++;
                $display("FAIL rstmid_zero dut%0d: got %h expected 0", d, got[d]);
            end
        end
        i_reset = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d] !== {8'h11, 1'b1, 2'd1, 4'b0010} || got[d] !== exp_v[d]) begin
                miscompares++;
                $display("FAIL rstmid_regrant dut%0d: got %h expected %h", d, got[d], {8'h11, 1'b1, 2'd1, 4'b0010});
            end
        end
        i_req = '0;
    endtask

    task automatic test_gap3();
        int n = 0;
        longint prev = 0;
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        i_req = 4'b0011; i_data[0 +: W] = 8'hC0; i_data[W +: W] = 8'hC1;
        for (int c = 0; c < 24; c++) begin
            tick();
            vectors++;
            if (got[1] !== exp_v[1]) begin
                miscompares++;
                $display("FAIL gap3 dut1: got %h expected %h", got[1], exp_v[1]);
            end
            if (a1) begin
                vectors++;
                if (n > 0 && edge_n - prev != 4) begin
                    miscompares++;
                    $display("FAIL gap3_spacing: got %0d expected 4", edge_n - prev);
                end
                prev = edge_n; n++;
            end
        end
        vectors++;
        if (n != 6) begin
            miscompares++;
            $display("FAIL gap3_count: got %0d expected 6", n);
        end
        i_req = '0;
    endtask

    task automatic test_lock();
`ifdef CHAR_ARB_LOCK_EN
        int exp_seq [4] = '{0, 0, 0, 1};
`else
        int exp_seq [4] = '{0, 1, 0, 0};
`endif
        int n = 0, b0 = 0;
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        i_req = 4'b0011; i_last = 4'b0000;
        i_data[0 +: W] = 8'hA0; i_data[W +: W] = 8'hB0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            vectors++;
            if (got[0] !== exp_v[0]) begin
                miscompares++;
                $display("FAIL lock dut0: got %h expected %h", got[0], exp_v[0]);
            end
            if (a0) begin
                vectors++;
                if (int'(s0) != exp_seq[n]) begin
                    miscompares++;
                    $display("FAIL lock_seq[%0d]: got src %0d expected %0d", n, s0, exp_seq[n]);
                end
                n++;
                if (s0 == 2'd0) begin
                    b0++;
                    i_data[0 +: W] = 8'hA0 + 8'(b0);
                    i_last[0] = (b0 == 2);
                    if (b0 == 3) i_req[0] = 1'b0;
                end else begin
                    i_req[1] = 1'b0;
                end
            end
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL lock_count: got %0d expected 4", n);
        end
        i_req = '0; i_last = '0;
    endtask

    task automatic test_random();
        i_reset = 1'b1; tick(); i_reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            i_req   = 4'($urandom);
            i_last  = 4'($urandom);
            i_busy  = ($urandom_range(0, 3) == 0);
            i_reset = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < N; k++) i_data[k*W +: W] = 8'($urandom);
            tick();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (got[d] !== exp_v[d]) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc %0d: got %h expected %h", d, c, got[d], exp_v[d]);
                end
            end
        end
        i_reset = 1'b0; i_busy = 1'b0; i_req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy();
        test_reset_mid();
        test_gap3();
        test_lock();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/char_arbiter.md
# char_arbiter

Round-robin arbiter that shares one byte-strobe output channel (`o_data` plus a one-cycle `o_act` strobe) between N character sources. It feeds the downstream serializer/transmitter in the same design. It honours the serializer's `i_busy` and enforces a minimum gap between strobes. It returns a one-cycle acknowledge to the source whose byte was issued.

## Interface
Parameters:
- `N`, 4: number of requesters; must be ≥2.
- `W`, 8: data width per requester.
- `GAP`, 1: idle cycles forced after each strobe; must be ≥1.

Ports:
- `i_clock`, input, 1: clock; all logic on the rising edge.
- `i_reset`, input, 1: reset; synchronous, active-high.
- `i_req`, input, N: per-source request level.
- `i_data`, input, N*W: source k's byte on `[k*W +: W]`.
- `i_last`, input, N: source k's current byte ends a packet. Used only with `CHAR_ARB_LOCK_EN`.
- `i_busy`, input, 1: downstream cannot accept a strobe.
- `o_data`, output, W: issued byte; 0 when `o_act`=0.
- `o_act`, output, 1: one-cycle issue strobe.
- `o_src`, output, clog2(N): index of the issuing source; 0 when `o_act`=0.
- `o_ack`, output, N: one-hot, one-cycle acknowledge, coincident with `o_act`.

## Operation
- All outputs are registered.
- Reset values: `o_data`=0, `o_act`=0, `o_src`=0, `o_ack`=0. Internal state resets to state IDLE, pointer `last`=N-1, gap counter 0, lock cleared.
- **IDLE state:**
  - Arbitration happens on an edge where the state is IDLE, `i_busy`=0 and `|i_req`=1.
  - The winner is the first asserted `i_req` searching from index `last+1` upward, modulo N.
  - On that edge the block registers `o_data`=`i_data[k]`, `o_act`=1, `o_src`=k, `o_ack`=1<<k and `last`=k. It then enters GAP with the counter set to GAP.
- **GAP state:**
  - `o_act` and `o_ack` return to 0 on the first GAP cycle; `o_data` returns to 0 at the same time.
  - The counter decrements each cycle. When it reaches 0 the block moves to IDLE.
  - Requests and `i_busy` are ignored while in GAP.
- If `i_busy`=1 in IDLE, the block stalls with no output change, however long busy is held.
- Source contract:
  - Hold `i_req` and `i_data` stable until `o_ack[k]`.
  - Present the next byte or drop `i_req` on the cycle after the ack.
  - A request dropped before its ack is legal; it is simply not granted.
- No starvation: with all N sources requesting continuously, each source is granted exactly once per N strobes.

## Timing
- Request-to-strobe latency: 1 cycle. Request sampled on edge t (IDLE, not busy) gives `o_act` high during cycle t+1.
- Minimum strobe spacing: GAP+1 cycles. With GAP=1, back-to-back requesters produce `o_act` every 2 cycles.
- `i_busy` is sampled only in IDLE. The downstream must assert `i_busy` within GAP cycles after `o_act` if it needs more time.
- Simultaneous events:
  - Request and busy together: busy wins and the request stays pending.
  - Reset wins over everything.
- Reset mid-GAP or on a strobe cycle: outputs are 0 in the next cycle. The first new strobe can appear 1 cycle after `i_reset` deasserts, and source 0 has top priority.
- Wrap-around: with `last`=N-1, the search starts at 0.

## Configuration
- Macro: `CHAR_ARB_LOCK_EN`.
- **Defined (packet lock):**
  - When source k is granted with `i_last[k]`=0, the lock is set to k.
  - While the lock is set, only source k is eligible. Other requests wait even if k is idle.
  - A grant with `i_last[k]`=1 clears the lock.
  - Reset clears the lock.
- **Undefined:** `i_last` is ignored, no lock register is built, and arbitration is pure per-byte round-robin.

## Test plan
- Reset, then source 2 alone requests `i_data[2]`=8'h41 → one cycle later `o_act`=1, `o_data`=8'h41, `o_src`=2, `o_ack`=4'b0100; all outputs 0 on the next cycle.
- Sources 0–3 request continuously with bytes 8'h30..8'h33, GAP=1 → strobes every 2 cycles carrying 30,31,32,33,30,… with `o_src` 0,1,2,3,0.
- Hold `i_busy`=1 for 10 cycles while source 1 requests → no `o_act` during busy; strobe appears 1 cycle after busy drops.
- Assert `i_reset` on the `o_act` cycle with sources 1 and 3 pending → outputs 0 next cycle; first grant after release goes to source 1.
- GAP=3, two sources requesting → `o_act` spacing is exactly 4 cycles.
- With `CHAR_ARB_LOCK_EN`, source 0 sends 3 bytes (`i_last` only on the 3rd) while source 1 requests → three source-0 strobes, then source 1. Without the macro, the bench checks alternation 0,1,0,…
